npu_axi_sram_responder: RTL and testbench
=========================================

// Module: npu_axi_sram_responder
// PURPOSE
//  Synthesizable AXI4 subordinate (responder) backing the NPU shell's 256-bit m_axi master port with local dual-port SRAM.
//  Serves DMA_COPY and GEMM traffic from npu_top in FPGA bring-up and in benches that need a cycle-accurate memory.
//  Independent write (AW/W/B) and read (AR/R) engines run concurrently. INCR bursts only; one outstanding burst per direction.
// PARAMETERS
//  DATA_W      256      beat width in bits; beat = DATA_W/8 bytes
//  ADDR_W      64       AXI address width
//  DEPTH       65536    SRAM depth in beats (2 MiB at default); power of two
//  BASE_ADDR   64'h0    byte address mapped to beat 0
// PORTS
//  clk            in   1        single clock
//  rst_n          in   1        asynchronous active-low reset
//  s_axi_awvalid  in   1        write address valid
//  s_axi_awready  out  1        write address ready
//  s_axi_awaddr   in   ADDR_W   burst start byte address
//  s_axi_awlen    in   8        beats-1
//  s_axi_awsize   in   3        log2 bytes/beat (accepted, not used for addressing)
//  s_axi_wvalid   in   1        write data valid
//  s_axi_wready   out  1        write data ready
//  s_axi_wdata    in   DATA_W   write data
//  s_axi_wstrb    in   DATA_W/8 byte enables
//  s_axi_wlast    in   1        last write beat
//  s_axi_bvalid   out  1        write response valid (always OKAY; no bresp)
//  s_axi_bready   in   1        write response ready
//  s_axi_arvalid  in   1        read address valid
//  s_axi_arready  out  1        read address ready
//  s_axi_araddr   in   ADDR_W   burst start byte address
//  s_axi_arlen    in   8        beats-1
//  s_axi_arsize   in   3        accepted, unused
//  s_axi_rvalid   out  1        read data valid
//  s_axi_rready   in   1        read data ready
//  s_axi_rdata    out  DATA_W   read data
//  s_axi_rlast    out  1        last read beat
//  err_wlast      out  1        sticky wlast/beat-count mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0 (awready/arready 0 while rst_n low, 1 on first clk after release); FSMs to IDLE; SRAM contents not cleared.
//  Addressing: beat index = ((addr - BASE_ADDR) >> log2(DATA_W/8)) mod DEPTH; low offset bits ignored; +1 per beat, wraps DEPTH-1 -> 0.
//  Write FSM: W_IDLE (awready=1) --AW hs--> W_DATA (wready=1, latch idx, cnt=awlen) --W hs, cnt==0--> W_RESP (bvalid=1) --B hs--> W_IDLE.
//   Each W hs writes bytes with wstrb=1 at idx; strb=0 bytes untouched. Termination is by beat count; wlast is only checked.
//   bvalid rises the cycle after the final W hs and holds until bready; awready stays 0 from AW hs until B hs.
//  Read FSM: R_IDLE (arready=1) --AR hs--> R_BURST --final R hs--> R_IDLE.
//   Synchronous SRAM read: rvalid rises the cycle after AR hs. Output reg reloads when (!rvalid || rready) and beats remain,
//   giving 1 beat/clk with rready held high. rdata/rlast stay stable while rvalid && !rready. rlast = 1 on beat arlen only.
//   arready stays 0 from AR hs through final R hs.
//  Same-beat read/write in one cycle: read returns the pre-write data (read-first).
//  Reset mid-burst: the burst is abandoned immediately. No B or R beats are emitted for it. Partially written beats remain in SRAM.
//  awlen=0 / arlen=0: single-beat burst. awlen=255: 256 beats, wrap applies.
// CONFIGURATION
//  NPU_AXI_SRAM_WLAST_CHECK_EN defined: err_wlast is set sticky (cleared only by reset) when wlast=1 on a non-final beat or wlast=0 on the final beat.
//   Sim additionally issues $error on each mismatch.
//  Undefined: err_wlast tied 0 and the check logic is not built. Data path behaviour is identical in both cases.
// STRUCTURE
//  Package npu_axi_pkg: AXI_LEN_W=8, AXI_SIZE_W=3, beat-bytes function, wr_state_e {W_IDLE,W_DATA,W_RESP}, rd_state_e {R_IDLE,R_BURST}.
//  SRAM array `mem` [DEPTH][DATA_W] is inferred in this module. Benches use it as a backdoor via hierarchical reference.
//  Sub-module npu_axi_sram_rd_pipe holds the read beat counter, index, output register and stall hold.
// TESTING
//  1 AW 0x1000 len=7, 8 beats pattern k*0x01010101 -> bvalid 1 clk after 8th beat; AR 0x1000 len=7 returns the same 8 beats, rlast on beat 7.
//  2 Write beat 0x2000 all-ones, then wstrb=0x0000000F with 0 data -> readback: bytes 0-3 = 0, bytes 4-31 = 0xFF.
//  3 AR len=15 with rready toggling 1,0,0,1 -> rdata/rlast stable on stalls; 16 beats in order; no drop or duplicate.
//  4 AW at beat DEPTH-2, len=3 -> beats land at DEPTH-2, DEPTH-1, 0, 1 (checked via backdoor).
//  5 Concurrent AW len=3 @0x0 and AR len=3 @0x0 in the same cycle -> both complete; read beat 0 returns old data (read-first).
//  6 With NPU_AXI_SRAM_WLAST_CHECK_EN: wlast on beat 1 of a len=3 burst -> err_wlast=1 from next clk, burst still takes 4 beats; without the macro err_wlast=0.

Source files
------------

// File: rtl/npu_axi_pkg.sv
// Shared types and constants for the NPU AXI4 SRAM responder.
package npu_axi_pkg;

  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_BURST}        rd_state_e;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/npu_axi_sram_rd_pipe.sv
// Read-burst engine: beat counter, SRAM index, registered output beat and stall hold.
module npu_axi_sram_rd_pipe
  import npu_axi_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int IDX_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [IDX_W-1:0]     i_start_idx,
  input  logic [AXI_LEN_W-1:0] i_len,
  input  logic                 i_rready,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic [IDX_W-1:0]     o_mem_idx,
  output logic                 o_rvalid,
  output logic [DATA_W-1:0]    o_rdata,
  output logic                 o_rlast,
  output logic                 o_done
);

  logic [IDX_W-1:0]     r_idx;
  logic [AXI_LEN_W-1:0] r_left;
  logic                 r_rvalid;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_rlast;
  logic                 w_advance;

  // The output register only reloads once the current beat is consumed.
  assign w_advance = (!r_rvalid || i_rready) && (r_left != '0);
  assign o_mem_idx = i_start ? i_start_idx : r_idx;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_left   <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rlast  <= 1'b0;
    end else if (i_start) begin
      r_rdata  <= i_mem_rdata;
      r_rvalid <= 1'b1;
      r_rlast  <= (i_len == '0);
      r_idx    <= i_start_idx + IDX_W'(1);
      r_left   <= i_len;
    end else if (w_advance) begin
      r_rdata  <= i_mem_rdata;
      r_rvalid <= 1'b1;
      r_rlast  <= (r_left == AXI_LEN_W'(1));
      r_idx    <= r_idx + IDX_W'(1);
      r_left   <= r_left - AXI_LEN_W'(1);
    end else if (r_rvalid && i_rready) begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_rlast  = r_rlast;
  assign o_done   = r_rvalid && i_rready && r_rlast;

endmodule

// File: rtl/npu_axi_sram_responder.sv
// AXI4 INCR-only SRAM responder with independent write and read engines.
// Optional wlast checking is built when NPU_AXI_SRAM_WLAST_CHECK_EN is defined.
module npu_axi_sram_responder
  import npu_axi_pkg::*;
#(
  parameter int                DATA_W    = 256,
  parameter int                ADDR_W    = 64,
  parameter int                DEPTH     = 65536,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [AXI_LEN_W-1:0]  s_axi_awlen,
  input  logic [AXI_SIZE_W-1:0] s_axi_awsize,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wlast,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [AXI_LEN_W-1:0]  s_axi_arlen,
  input  logic [AXI_SIZE_W-1:0] s_axi_arsize,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic                  s_axi_rlast,
  output logic                  err_wlast
);

  localparam int STRB_W = beat_bytes(DATA_W);
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  wr_state_e            r_wr_state, w_wr_next;
  rd_state_e            r_rd_state, w_rd_next;
  logic                 r_live;
  logic [IDX_W-1:0]     r_widx;
  logic [AXI_LEN_W-1:0] r_wcnt;
  logic [ADDR_W-1:0]    w_aw_off, w_ar_off;
  logic [IDX_W-1:0]     w_aw_idx, w_ar_idx, w_rd_idx;
  logic [DATA_W-1:0]    w_mem_rdata;
  logic                 w_aw_hs, w_w_hs, w_ar_hs, w_rd_done;

  assign w_aw_off = s_axi_awaddr - BASE_ADDR;
  assign w_ar_off = s_axi_araddr - BASE_ADDR;
  assign w_aw_idx = w_aw_off[OFF_W +: IDX_W];
  assign w_ar_idx = w_ar_off[OFF_W +: IDX_W];

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;

  // Holds the address-ready outputs low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= W_IDLE;
      r_widx     <= '0;
      r_wcnt     <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_aw_hs) begin
        r_widx <= w_aw_idx;
        r_wcnt <= s_axi_awlen;
      end else if (w_w_hs) begin
        r_widx <= r_widx + IDX_W'(1);
        r_wcnt <= r_wcnt - AXI_LEN_W'(1);
      end
    end
  end

  // NOTE: every output of a combinational process gets a default first, so no path infers a latch.
  always_comb begin
    w_wr_next     = r_wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (r_wr_state)
      W_IDLE: begin
        s_axi_awready = r_live;
        if (s_axi_awvalid && r_live) w_wr_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && (r_wcnt == '0)) w_wr_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  // NOTE: the SRAM array has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read sees the array before this edge's write lands, giving read-first behaviour.
  assign w_mem_rdata = mem[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_state <= R_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next     = r_rd_state;
    s_axi_arready = 1'b0;
    unique case (r_rd_state)
      R_IDLE: begin
        s_axi_arready = r_live;
        if (s_axi_arvalid && r_live) w_rd_next = R_BURST;
      end
      R_BURST: if (w_rd_done) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  npu_axi_sram_rd_pipe #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_ar_hs),
    .i_start_idx (w_ar_idx),
    .i_len       (s_axi_arlen),
    .i_rready    (s_axi_rready),
    .i_mem_rdata (w_mem_rdata),
    .o_mem_idx   (w_rd_idx),
    .o_rvalid    (s_axi_rvalid),
    .o_rdata     (s_axi_rdata),
    .o_rlast     (s_axi_rlast),
    .o_done      (w_rd_done)
  );

`ifdef NPU_AXI_SRAM_WLAST_CHECK_EN
  logic r_err_wlast;
  logic w_wlast_bad;
  logic w_unused_ok;

  assign w_wlast_bad = w_w_hs && (s_axi_wlast != (r_wcnt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_err_wlast <= 1'b0;
    else if (w_wlast_bad) r_err_wlast <= 1'b1;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !w_wlast_bad)
    else $error("wlast does not match burst beat count");

  assign err_wlast   = r_err_wlast;
  assign w_unused_ok = ^{s_axi_awsize, s_axi_arsize, w_aw_off, w_ar_off};
`else
  logic w_unused_ok;
  assign err_wlast   = 1'b0;
  assign w_unused_ok = ^{s_axi_awsize, s_axi_arsize, w_aw_off, w_ar_off, s_axi_wlast};
`endif

endmodule

// File: tb/tb_npu_axi_sram_responder.sv
// Scoreboard bench for npu_axi_sram_responder against a byte-array memory model.
`timescale 1ns/1ps
module tb_npu_axi_sram_responder;
  import npu_axi_pkg::*;

  localparam int          DATA_W = 256;
  localparam int          ADDR_W = 64;
  localparam int          DEPTH  = 1024;
  localparam int          STRB_W = DATA_W / 8;
  localparam logic [63:0] BASE   = 64'h0;
`ifdef NPU_AXI_SRAM_WLAST_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  awvalid = 1'b0, awready;
  logic [ADDR_W-1:0]     awaddr = '0;
  logic [7:0]            awlen = '0;
  logic [2:0]            awsize = '0;
  logic                  wvalid = 1'b0, wready;
  logic [DATA_W-1:0]     wdata = '0;
  logic [STRB_W-1:0]     wstrb = '0;
  logic                  wlast = 1'b0;
  logic                  bvalid, bready = 1'b0;
  logic                  arvalid = 1'b0, arready;
  logic [ADDR_W-1:0]     araddr = '0;
  logic [7:0]            arlen = '0;
  logic [2:0]            arsize = '0;
  logic                  rvalid, rready = 1'b0;
  logic [DATA_W-1:0]     rdata;
  logic                  rlast;
  logic                  err_wlast;

  always #5 clk = ~clk;

  npu_axi_sram_responder #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rlast   (rlast),
    .err_wlast     (err_wlast)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } rbeat_t;

  int                total = 0;
  int                bad = 0;
  int                bexp = 0;
  logic [DATA_W-1:0] model [DEPTH];
  rbeat_t            rq [$];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [63:0] a);
    return int'(((a - BASE) / 64'(STRB_W)) % 64'(DEPTH));
  endfunction

  function automatic logic [DATA_W-1:0] rand_beat();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: pops expected R beats, counts B responses, checks stall stability.
  logic              stall_q = 1'b0;
  logic [DATA_W-1:0] rdata_q;
  logic              rlast_q;
  always @(negedge clk) begin
    rbeat_t e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("r_stall_valid", rvalid, 1);
        check("r_stall_data", rdata, rdata_q);
        check("r_stall_last", rlast, rlast_q);
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check("r_extra_beat", rvalid, 0);
        else begin
          e = rq.pop_front();
          check("r_data", rdata, e.data);
          check("r_last", rlast, e.last);
        end
      end
      stall_q = rvalid && !rready;
      rdata_q = rdata;
      rlast_q = rlast;
      if (bvalid && bready) begin
        check("b_expected", (bexp > 0), 1);
        if (bexp > 0) bexp--;
      end
    end
  end

  // dmode: 0 k*0x01010101 pattern, 1 random, 2 all ones, 3 zeros. smode: 0 full, 1 0xF, 2 random.
  task automatic do_write(input logic [63:0] addr, input int len, input int dmode, input int smode,
                          input int bad_last, input int abort_after);
    int                idx, n;
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
    idx = idx_of(addr);
    if (abort_after < 0) bexp++;
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = addr; awlen = len[7:0]; awsize = 3'd5;
    n = 0;
    while (!awready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin check("aw_timeout", awready, 1); awvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (k == abort_after) return;
      case (dmode)
        0:       d = {8{32'(k) * 32'h01010101}};
        1:       d = rand_beat();
        2:       d = '1;
        default: d = '0;
      endcase
      case (smode)
        0:       s = '1;
        1:       s = 32'h0000000F;
        default: s = $urandom;
      endcase
      wvalid = 1'b1; wdata = d; wstrb = s;
      wlast = (bad_last >= 0) ? (k == bad_last) : (k == len);
      n = 0;
      while (!wready && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) begin check("w_timeout", wready, 1); wvalid = 1'b0; return; end
      check("b_early", bvalid, 0);
      @(posedge clk); #1;
      for (int b = 0; b < STRB_W; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      idx = (idx + 1) % DEPTH;
      if (bad_last >= 0) check("err_wlast", err_wlast, (k >= bad_last) ? ERR_EN : 1'b0);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_timing", bvalid, 1);
    check("aw_busy", awready, 0);
    n = 0;
    forever begin
      bready = ($urandom_range(0, 2) != 0);
      if (bvalid && bready) break;
      @(posedge clk); #1; n++;
      if (n > 200) begin check("b_timeout", bvalid, 1); bready = 1'b0; return; end
    end
    @(posedge clk); #1;
    bready = 1'b0;
    check("aw_ready_after_b", awready, 1);
  endtask

  // rmode: 0 rready held, 1 pattern 1,0,0,1, 2 random.
  task automatic do_read(input logic [63:0] addr, input int len, input int rmode);
    int idx, n, ph;
    idx = idx_of(addr);
    for (int k = 0; k <= len; k++) begin
      rq.push_back('{data: model[idx], last: (k == len)});
      idx = (idx + 1) % DEPTH;
    end
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = addr; arlen = len[7:0]; arsize = 3'd5;
    rready = (rmode == 0);
    n = 0;
    while (!arready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin check("ar_timeout", arready, 1); arvalid = 1'b0; rq.delete(); return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("r_first_latency", rvalid, 1);
    check("ar_busy", arready, 0);
    ph = 0; n = 0;
    while (rq.size() != 0 && n < 2000) begin
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = (ph % 4 == 0) || (ph % 4 == 3);
        default: rready = $urandom_range(0, 1) == 1;
      endcase
      ph++;
      @(posedge clk); #1; n++;
    end
    rready = 1'b0;
    check("r_drain", rq.size(), 0);
    rq.delete();
    check("ar_ready_after_r", arready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] v;
    logic [63:0]       a;
    int                len, base_idx;

    for (int i = 0; i < DEPTH; i++) begin
      v = rand_beat();
      dut.mem[i] = v;
      model[i] = v;
    end

    // Reset state
    #22;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err_wlast, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rel_awready_early", awready, 0);
    @(posedge clk); #1;
    check("rel_awready", awready, 1);
    check("rel_arready", arready, 1);

    // Pattern burst and readback
    do_write(64'h1000, 7, 0, 0, -1, -1);
    do_read(64'h1000, 7, 0);

    // Byte strobes
    do_write(64'h2000, 0, 2, 0, -1, -1);
    do_write(64'h2000, 0, 3, 1, -1, -1);
    do_read(64'h2000, 0, 0);
    v = {{224{1'b1}}, 32'h0};
    check("strb_backdoor", dut.mem[idx_of(64'h2000)], v);

    // Stalled read
    do_write(64'h4000, 15, 1, 0, -1, -1);
    do_read(64'h4000, 15, 1);

    // Wrap at end of array
    a = 64'((DEPTH - 2) * STRB_W);
    do_write(a, 3, 1, 0, -1, -1);
    check("wrap_m2", dut.mem[DEPTH-2], model[DEPTH-2]);
    check("wrap_m1", dut.mem[DEPTH-1], model[DEPTH-1]);
    check("wrap_0", dut.mem[0], model[0]);
    check("wrap_1", dut.mem[1], model[1]);
    do_read(a, 3, 2);

    // Concurrent write and read of the same beats
    fork
      do_write(64'h0, 3, 1, 0, -1, -1);
      do_read(64'h0, 3, 0);
    join
    do_read(64'h0, 3, 0);

    // Early wlast
    do_write(64'h5000, 3, 1, 2, 1, -1);
    check("err_wlast_hold", err_wlast, ERR_EN);
    do_read(64'h5000, 3, 0);

    // Randomized traffic, including a 256-beat burst with wrap
    for (int t = 0; t < 10; t++) begin
      a   = 64'($urandom_range(0, 2 * DEPTH * STRB_W - 1));
      len = $urandom_range(0, 31);
      do_write(a, len, 1, 2, -1, -1);
      do_read(a, len, 2);
    end
    a = 64'((DEPTH - 100) * STRB_W + 5);
    do_write(a, 255, 1, 0, -1, -1);
    do_read(a, 255, 2);

    // Reset mid-burst: three beats land, fourth is untouched, no response
    base_idx = idx_of(64'h3000);
    do_write(64'h3000, 7, 1, 0, -1, 3);
    rst_n = 1'b0;
    wvalid = 1'b0;
    #1;
    check("mid_rst_wready", wready, 0);
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_awready", awready, 0);
    check("mid_rst_err", err_wlast, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_awready", awready, 1);
    check("post_rst_bvalid", bvalid, 0);
    for (int k = 0; k < 4; k++) check("mid_rst_mem", dut.mem[(base_idx + k) % DEPTH], model[(base_idx + k) % DEPTH]);
    do_read(64'h3000, 7, 0);

    repeat (4) @(posedge clk);
    #1;
    check("b_outstanding", bexp, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
